// File: rtl/div_pkg.sv
// Shared constants for the repeated-subtraction divider and its BCD output stage.
// The optional divide-by-zero path (DIV_BCD_DBZ_EN) uses BCD_BLANK as its display-blank digit.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_DIGITS = 3;
   localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/div_bcd_out_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 (mod 16) so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/div_bcd_out.sv
// Converts a divider quotient/remainder pair to packed BCD, one bit per clock, and hands it on via valid/ready.
// Optional macro DIV_BCD_DBZ_EN adds in_dbz/out_err and a blank-display result for divide-by-zero.
module div_bcd_out
   import div_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_q,
   input  logic [WIDTH-1:0]      in_r,
`ifdef DIV_BCD_DBZ_EN
   input  logic                  in_dbz,
   output logic                  out_err,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_q_bcd,
   output logic [4*DIGITS-1:0]   out_r_bcd
);

   localparam int BW = 4 * DIGITS;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   q_bin_q, r_bin_q;
   logic [BW-1:0]      q_acc_q, r_acc_q;
   logic [BW-1:0]      out_q_bcd_q, out_r_bcd_q;
   logic               in_ready_q, out_valid_q;
`ifdef DIV_BCD_DBZ_EN
   logic               dbz_q, out_err_q;
`endif

   logic [BW-1:0]      q_adj, r_adj;
   logic [BW+WIDTH:0]  q_wide, r_wide;
   logic [BW-1:0]      q_acc_d, r_acc_d;
   logic [WIDTH-1:0]   q_bin_d, r_bin_d;
   logic               last_shift;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_add3 u_q_add3 (.digit_i(q_acc_q[4*gi +: 4]), .digit_o(q_adj[4*gi +: 4]));
         bcd_add3 u_r_add3 (.digit_i(r_acc_q[4*gi +: 4]), .digit_o(r_adj[4*gi +: 4]));
      end
   endgenerate

   // {bcd,bin} shifted left by one; the top bit falls off and is never needed.
   assign q_wide  = {q_adj, q_bin_q, 1'b0};
   assign r_wide  = {r_adj, r_bin_q, 1'b0};
   assign q_acc_d = q_wide[BW+WIDTH-1:WIDTH];
   assign r_acc_d = r_wide[BW+WIDTH-1:WIDTH];
   assign q_bin_d = q_wide[WIDTH-1:0];
   assign r_bin_d = r_wide[WIDTH-1:0];

   logic unused_shift_out;
   assign unused_shift_out = &{1'b0, q_wide[BW+WIDTH], r_wide[BW+WIDTH]};

   assign last_shift = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         q_bin_q     <= '0;
         r_bin_q     <= '0;
         q_acc_q     <= '0;
         r_acc_q     <= '0;
         out_q_bcd_q <= '0;
         out_r_bcd_q <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef DIV_BCD_DBZ_EN
         dbz_q       <= 1'b0;
         out_err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  q_bin_q    <= in_q;
                  r_bin_q    <= in_r;
                  q_acc_q    <= '0;
                  r_acc_q    <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= SHIFT;
`ifdef DIV_BCD_DBZ_EN
                  dbz_q      <= in_dbz;
                  out_err_q  <= 1'b0;
`endif
               end
            end
            SHIFT: begin
`ifdef DIV_BCD_DBZ_EN
               // A divide-by-zero pair spends a single cycle here and never shifts.
               if (dbz_q) begin
                  out_q_bcd_q <= {DIGITS{BCD_BLANK}};
                  out_r_bcd_q <= {DIGITS{BCD_BLANK}};
                  out_err_q   <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
`endif
                  q_acc_q <= q_acc_d;
                  r_acc_q <= r_acc_d;
                  q_bin_q <= q_bin_d;
                  r_bin_q <= r_bin_d;
                  cnt_q   <= cnt_q + 1'b1;
                  if (last_shift) begin
                     out_q_bcd_q <= q_acc_d;
                     out_r_bcd_q <= r_acc_d;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
`ifdef DIV_BCD_DBZ_EN
               end
`endif
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_q_bcd = out_q_bcd_q;
   assign out_r_bcd = out_r_bcd_q;
`ifdef DIV_BCD_DBZ_EN
   assign out_err   = out_err_q;
`endif

endmodule

// File: tb/tb_div_bcd_out.sv
// Self-checking bench for div_bcd_out: expected BCD pairs are queued at each accept
// and compared when the result is presented. Define DIV_BCD_DBZ_EN to cover the blank path.
module tb_div_bcd_out;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_q = '0;
   logic [7:0]  in_r = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [11:0] out_q_bcd;
   logic [11:0] out_r_bcd;
`ifdef DIV_BCD_DBZ_EN
   logic        in_dbz = 1'b0;
   logic        out_err;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [23:0] sb[$];

   always #5 clk = ~clk;

   div_bcd_out dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_q      (in_q),
      .in_r      (in_r),
`ifdef DIV_BCD_DBZ_EN
      .in_dbz    (in_dbz),
      .out_err   (out_err),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_q_bcd (out_q_bcd),
      .out_r_bcd (out_r_bcd)
   );

   function automatic logic [11:0] bcd_ref(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a pair, queues its expected BCD and returns after the accept edge.
   task automatic send_pair(input int q, input int r, output bit timed_out);
      int n;
      in_q = 8'(q);
      in_r = 8'(r);
      in_valid = 1'b1;
      sb.push_back({bcd_ref(q), bcd_ref(r)});
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      timed_out = !in_ready;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_q_bcd !== 12'h000 || out_r_bcd !== 12'h000) begin
         miscompares++;
         $display("FAIL reset: in_ready=%b out_valid=%b q=%h r=%h, required 1 0 000 000",
                  in_ready, out_valid, out_q_bcd, out_r_bcd);
      end
`ifdef DIV_BCD_DBZ_EN
      vectors++;
      if (out_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_err: out_err=%b, required 0", out_err);
      end
`endif
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      int n;
      bit busy_bad;
      logic [23:0] exp;
      out_ready = 1'b1;
      in_q = 8'd255;
      in_r = 8'd0;
      in_valid = 1'b1;
      sb.push_back({bcd_ref(255), bcd_ref(0)});
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL latency_ready: in_ready=%b before accept, required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      n = 0;
      busy_bad = 1'b0;
      while (!out_valid && n < 50) begin
         if (in_ready !== 1'b0) busy_bad = 1'b1;
         tick();
         n++;
      end
      vectors++;
      if (n != 8) begin
         miscompares++;
         $display("FAIL latency: out_valid after %0d clocks, required 8", n);
      end
      vectors++;
      if (busy_bad) begin
         miscompares++;
         $display("FAIL busy_ready: in_ready seen 1 during conversion, required 0");
      end
      exp = sb.pop_front();
      vectors++;
      if ({out_q_bcd, out_r_bcd} !== exp) begin
         miscompares++;
         $display("FAIL pair 255/0: got %h/%h, required %h/%h", out_q_bcd, out_r_bcd, exp[23:12], exp[11:0]);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_hold();
      int n;
      bit to;
      logic [23:0] exp;
      out_ready = 1'b0;
      send_pair(100, 7, to);
      n = 0;
      while (!out_valid && n < 50) begin
         in_valid = n[0];
         in_q = 8'd33;
         tick();
         n++;
      end
      exp = sb.pop_front();
      vectors++;
      if (to || n >= 50 || {out_q_bcd, out_r_bcd} !== exp) begin
         miscompares++;
         $display("FAIL hold_first: got %h/%h after %0d clocks, required %h/%h",
                  out_q_bcd, out_r_bcd, n, exp[23:12], exp[11:0]);
      end
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         in_q = 8'(k);
         tick();
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_q_bcd, out_r_bcd} !== exp) begin
            miscompares++;
            $display("FAIL hold_%0d: valid=%b ready=%b got %h/%h, required 1 0 %h/%h",
                     k, out_valid, in_ready, out_q_bcd, out_r_bcd, exp[23:12], exp[11:0]);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      tick();
      tick();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int pq[3] = '{13, 0, 99};
      int pr[3] = '{4, 0, 98};
      int idx = 0, got = 0, c = 0, last_acc = -1;
      bit acc_now;
      logic [23:0] exp;
      out_ready = 1'b1;
      in_q = 8'(pq[0]);
      in_r = 8'(pr[0]);
      in_valid = 1'b1;
      while (got < 3 && c < 200) begin
         acc_now = in_valid && in_ready;
         if (acc_now) begin
            sb.push_back({bcd_ref(pq[idx]), bcd_ref(pr[idx])});
            if (last_acc >= 0) begin
               vectors++;
               if (c - last_acc != 10) begin
                  miscompares++;
                  $display("FAIL b2b_spacing: accept %0d came %0d clocks after previous, required 10",
                           idx, c - last_acc);
               end
            end
            last_acc = c;
         end
         if (out_valid) begin
            exp = sb.pop_front();
            vectors++;
            if ({out_q_bcd, out_r_bcd} !== exp) begin
               miscompares++;
               $display("FAIL b2b_%0d: got %h/%h, required %h/%h", got,
                        out_q_bcd, out_r_bcd, exp[23:12], exp[11:0]);
            end
            got++;
         end
         tick();
         c++;
         if (acc_now) begin
            idx++;
            if (idx < 3) begin
               in_q = 8'(pq[idx]);
               in_r = 8'(pr[idx]);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (got != 3) begin
         miscompares++;
         $display("FAIL b2b_count: %0d results seen, required 3", got);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit to;
      logic [23:0] exp;
      out_ready = 1'b1;
      in_q = 8'd200;
      in_r = 8'd55;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_q_bcd !== 12'h000 || out_r_bcd !== 12'h000) begin
         miscompares++;
         $display("FAIL mid_reset: valid=%b ready=%b q=%h r=%h, required 0 1 000 000",
                  out_valid, in_ready, out_q_bcd, out_r_bcd);
      end
      tick();
      rst_n = 1'b1;
      tick();
      send_pair(42, 1, to);
      wait_valid(n);
      exp = sb.pop_front();
      vectors++;
      if (to || n != 8 || {out_q_bcd, out_r_bcd} !== exp) begin
         miscompares++;
         $display("FAIL after_reset: got %h/%h after %0d clocks, required %h/%h after 8",
                  out_q_bcd, out_r_bcd, n, exp[23:12], exp[11:0]);
      end
      tick();
   endtask

   task automatic test_sweep();
      int n;
      bit to, bad_digit;
      logic [23:0] exp;
      out_ready = 1'b1;
      for (int v = 0; v < 256; v++) begin
         send_pair(v, 255 - v, to);
         wait_valid(n);
         exp = sb.pop_front();
         vectors++;
         if (to || n >= 50 || {out_q_bcd, out_r_bcd} !== exp) begin
            miscompares++;
            $display("FAIL sweep %0d/%0d: got %h/%h, required %h/%h", v, 255 - v,
                     out_q_bcd, out_r_bcd, exp[23:12], exp[11:0]);
         end
         bad_digit = 1'b0;
         for (int d = 0; d < 3; d++) begin
            if (out_q_bcd[4*d +: 4] > 4'd9 || out_r_bcd[4*d +: 4] > 4'd9) bad_digit = 1'b1;
         end
         vectors++;
         if (bad_digit) begin
            miscompares++;
            $display("FAIL sweep_digit %0d: got %h/%h, required all digits <= 9", v, out_q_bcd, out_r_bcd);
         end
         tick();
      end
   endtask

`ifdef DIV_BCD_DBZ_EN
   task automatic test_dbz();
      int n;
      bit to;
      logic [23:0] exp;
      out_ready = 1'b1;
      in_dbz = 1'b1;
      in_q = 8'd7;
      in_r = 8'd0;
      in_valid = 1'b1;
      sb.push_back(24'hFFF_FFF);
      tick();
      in_valid = 1'b0;
      in_dbz = 1'b0;
      wait_valid(n);
      exp = sb.pop_front();
      vectors++;
      if (n != 1 || out_err !== 1'b1 || {out_q_bcd, out_r_bcd} !== exp) begin
         miscompares++;
         $display("FAIL dbz: err=%b got %h/%h after %0d clocks, required 1 %h/%h after 1",
                  out_err, out_q_bcd, out_r_bcd, n, exp[23:12], exp[11:0]);
      end
      tick();
      send_pair(5, 2, to);
      vectors++;
      if (out_err !== 1'b0) begin
         miscompares++;
         $display("FAIL dbz_clear: out_err=%b after next accept, required 0", out_err);
      end
      wait_valid(n);
      exp = sb.pop_front();
      vectors++;
      if (to || n != 8 || out_err !== 1'b0 || {out_q_bcd, out_r_bcd} !== exp) begin
         miscompares++;
         $display("FAIL dbz_next: err=%b got %h/%h, required 0 %h/%h",
                  out_err, out_q_bcd, out_r_bcd, exp[23:12], exp[11:0]);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_hold();
      test_back_to_back();
      test_reset_mid();
`ifdef DIV_BCD_DBZ_EN
      test_dbz();
`endif
      test_sweep();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard: %0d results never presented, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
